// File: rtl/muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_seq_ctrl
//
// Sequencer for the shared iterative multiply/divide unit of the 5-stage core.
// One op is accepted from EX, front end (F/D) and EX are held via stall_D while
// the unit iterates one bit per cycle, and the result plus destination register
// are returned for writeback with a one-cycle md_done strobe.
//
// Flow: IDLE -> CALC -> FIX -> DONE -> IDLE (or DONE -> CALC when a new op is
// accepted in the DONE cycle). Multiply is shift-and-add on magnitudes; divide
// is restoring division on magnitudes; FIX applies signs and picks the half.
//
// Handshake: an op is taken when EX_md_valid is high, flush is low and the
// sequencer is in IDLE or DONE. There is no ready output; EX must keep the op
// presented while stall_D is high, and stall_D is asserted combinationally in
// the accept cycle itself. md_done is a single-cycle strobe with no back
// pressure; md_result/md_rd hold their values until the next DONE.
//
// Optional feature macro: MUL_EARLY_OUT_EN
//   defined     : a multiply leaves CALC as soon as the remaining multiplier
//                 bits are all zero (at least one CALC cycle).
//   not defined : every op spends exactly XLEN cycles in CALC.
//
// Ports
//   clk           in   core clock
//   rst_n         in   asynchronous active-low reset
//   EX_md_valid   in   EX holds a MUL/DIV op
//   EX_md_div     in   1 = divide, 0 = multiply
//   EX_md_signed  in   both operands are two's complement
//   EX_md_alt     in   mul: high half; div: remainder
//   EX_ra_val     in   operand A (multiplicand / dividend)
//   EX_rb_val     in   operand B (multiplier / divisor)
//   EX_rd         in   destination register
//   flush         in   kill in-flight op
//   stall_D       out  hold F/D and EX
//   md_busy       out  state is CALC or FIX
//   md_done       out  one-cycle result strobe
//   md_result     out  result, valid with md_done
//   md_rd         out  destination register of the result
//   md_we         out  md_done && md_rd != 0
//   md_state_dbg  out  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
// ---------------------------------------------------------------------------
module muldiv_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_md_valid,
  input  logic            EX_md_div,
  input  logic            EX_md_signed,
  input  logic            EX_md_alt,
  input  logic [XLEN-1:0] EX_ra_val,
  input  logic [XLEN-1:0] EX_rb_val,
  input  logic [4:0]      EX_rd,
  input  logic            flush,
  output logic            stall_D,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd,
  output logic            md_we,
  output logic [1:0]      md_state_dbg
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Operation attributes latched at accept
  logic             div_q, div_d;
  logic             alt_q, alt_d;
  logic             sign_a_q, sign_a_d;   // A was negative (signed op only)
  logic             sign_b_q, sign_b_d;   // B was negative (signed op only)
  logic             dvz_q, dvz_d;         // divisor is zero
  logic             ovf_q, ovf_d;         // signed MIN / -1
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Multiply datapath
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;

  // Divide datapath: quot_q starts as the dividend and quotient bits shift in
  // from the bottom as dividend bits leave from the top.
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;

  // Registered result outputs
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        res_rd_q, res_rd_d;

  logic              accept;
  logic              calc_last;
  logic              mul_last;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              a_neg, b_neg;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   fix_result;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  assign accept = EX_md_valid && !flush &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  assign a_neg = EX_md_signed && EX_ra_val[XLEN-1];
  assign b_neg = EX_md_signed && EX_rb_val[XLEN-1];
  assign a_mag = a_neg ? (~EX_ra_val + 1'b1) : EX_ra_val;
  assign b_mag = b_neg ? (~EX_rb_val + 1'b1) : EX_rb_val;

  // Last CALC iteration: the counter is about to hit zero, or (early-out) the
  // multiplier bit being consumed now is the last non-zero one.
`ifdef MUL_EARLY_OUT_EN
  assign mul_last = (mplier_q[XLEN-1:1] == '0) || (cnt_q == CNT_W'(1));
`else
  assign mul_last = (cnt_q == CNT_W'(1));
`endif
  assign calc_last = div_q ? (cnt_q == CNT_W'(1)) : mul_last;

  // Restoring step: one extra bit on the shifted remainder so large divisors
  // compare correctly; the subtraction itself always fits in XLEN bits.
  assign rem_sh  = {rem_q, quot_q[XLEN-1]};
  assign rem_sub = rem_sh[XLEN-1:0] - dvs_q;

  // Sign fix-up. Divide-by-zero returns all ones and the original dividend
  // (|A| re-signed with sign(A) is A). MIN/-1 is pinned explicitly.
  assign prod_fix = (sign_a_q ^ sign_b_q) ? (~prod_q + 1'b1) : prod_q;

  always_comb begin
    quot_fix = quot_q;
    rem_fix  = rem_q;
    if (dvz_q) begin
      quot_fix = '1;
    end else if (ovf_q) begin
      quot_fix = MIN_VAL;
    end else if (sign_a_q ^ sign_b_q) begin
      quot_fix = ~quot_q + 1'b1;
    end
    if (ovf_q) begin
      rem_fix = '0;
    end else if (sign_a_q) begin
      rem_fix = ~rem_q + 1'b1;
    end
  end

  always_comb begin
    fix_result = '0;
    if (div_q) begin
      fix_result = alt_q ? rem_fix : quot_fix;
    end else begin
      fix_result = alt_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        if (flush)          state_d = S_IDLE;
        else if (calc_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = accept ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    md_busy      = (state_q == S_CALC) || (state_q == S_FIX);
    stall_D      = md_busy || accept;
    md_done      = (state_q == S_DONE) && !flush;
    md_we        = md_done && (res_rd_q != 5'd0);
    md_result    = res_q;
    md_rd        = res_rd_q;
    md_state_dbg = state_q;
  end

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    div_d    = div_q;
    alt_d    = alt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dvz_d    = dvz_q;
    ovf_d    = ovf_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    res_rd_d = res_rd_q;

    if (accept) begin
      div_d    = EX_md_div;
      alt_d    = EX_md_alt;
      sign_a_d = a_neg;
      sign_b_d = b_neg;
      dvz_d    = (EX_rb_val == '0);
      ovf_d    = EX_md_signed && (EX_ra_val == MIN_VAL) && (EX_rb_val == '1);
      rd_d     = EX_rd;
      cnt_d    = CNT_W'(XLEN);
      prod_d   = '0;
      mcand_d  = {{XLEN{1'b0}}, a_mag};
      mplier_d = b_mag;
      rem_d    = '0;
      quot_d   = a_mag;
      dvs_d    = b_mag;
    end else if (state_q == S_CALC) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (div_q) begin
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d  = rem_sub;
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
      end
    end else if ((state_q == S_FIX) && !flush) begin
      res_d    = fix_result;
      res_rd_d = rd_q;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      alt_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      res_rd_q <= '0;
    end else begin
      div_q    <= div_d;
      alt_q    <= alt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dvz_q    <= dvz_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      res_rd_q <= res_rd_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

  localparam int XLEN = 32;
  localparam int W    = 1 + 5 + XLEN;   // {we, rd, result}

  logic            clk;
  logic            rst_n;
  logic            EX_md_valid;
  logic            EX_md_div;
  logic            EX_md_signed;
  logic            EX_md_alt;
  logic [XLEN-1:0] EX_ra_val;
  logic [XLEN-1:0] EX_rb_val;
  logic [4:0]      EX_rd;
  logic            flush;
  logic            stall_D;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [4:0]      md_rd;
  logic            md_we;
  logic [1:0]      md_state_dbg;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  muldiv_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .EX_md_valid  (EX_md_valid),
    .EX_md_div    (EX_md_div),
    .EX_md_signed (EX_md_signed),
    .EX_md_alt    (EX_md_alt),
    .EX_ra_val    (EX_ra_val),
    .EX_rb_val    (EX_rb_val),
    .EX_rd        (EX_rd),
    .flush        (flush),
    .stall_D      (stall_D),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_result    (md_result),
    .md_rd        (md_rd),
    .md_we        (md_we),
    .md_state_dbg (md_state_dbg)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- check
  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [XLEN-1:0] model(input bit div, input bit sgn,
                                            input bit alt,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [63:0] p;
    logic [XLEN-1:0] q, r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!div) begin
      if (sgn) p = sa * sb;
      else     p = {32'b0, a} * {32'b0, b};
      return alt ? p[63:32] : p[31:0];
    end
    if (b == 0) begin
      q = '1; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0;
    end else if (sgn) begin
      q = XLEN'(sa / sb); r = XLEN'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return alt ? r : q;
  endfunction

  function automatic int exp_lat(input bit div, input bit sgn,
                                 input logic [XLEN-1:0] b);
    int hb;
    logic [XLEN-1:0] m;
    hb = 0;
    m  = (sgn && b[XLEN-1]) ? (~b + 1'b1) : b;
`ifdef MUL_EARLY_OUT_EN
    if (!div) begin
      for (int i = 0; i < XLEN; i++) if (m[i]) hb = i;
      return hb + 3;
    end
`else
    if (m == '0 && hb != 0) return 0;
`endif
    return XLEN + 2;
  endfunction

  // ---------------------------------------------------------------- driver
  // Called just after a negedge; returns just after the accept edge.
  task automatic issue(input bit div, input bit sgn, input bit alt,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd, input bit push);
    EX_md_valid  = 1'b1;
    EX_md_div    = div;
    EX_md_signed = sgn;
    EX_md_alt    = alt;
    EX_ra_val    = a;
    EX_rb_val    = b;
    EX_rd        = rd;
    if (push) exp_q.push_back({rd != 5'd0, rd, model(div, sgn, alt, a, b)});
    #1;
    check_val("stall_accept", 64'(stall_D), 64'd1);
    @(posedge clk);
    #1;
    EX_md_valid = 1'b0;
  endtask

  // Counts cycles after the accept; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int lat);
    int cyc;
    logic stall_before;
    cyc = 0;
    stall_before = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == lat - 1) stall_before = stall_D;
      if (md_done) break;
      if (cyc > lat + 5) begin
        check_val({tag, "_timeout"}, 64'(cyc), 64'(lat));
        return;
      end
    end
    check_val({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_val({tag, "_stall_last"}, 64'(stall_before), 64'd1);
    check_val({tag, "_stall_done"}, 64'(stall_D), 64'd0);
  endtask

  task automatic run_op(input string tag, input bit div, input bit sgn,
                        input bit alt, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd);
    issue(div, sgn, alt, a, b, rd, 1'b1);
    wait_done(tag, exp_lat(div, sgn, b));
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (rst_n && md_done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 64'(md_done), 64'd0);
      end else begin
        check_val("result", 64'({md_we, md_rd, md_result}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [XLEN-1:0] ra, rb;
    bit rdiv, rsgn, ralt;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    EX_md_valid = 1'b0; EX_md_div = 1'b0; EX_md_signed = 1'b0; EX_md_alt = 1'b0;
    EX_ra_val = '0; EX_rb_val = '0; EX_rd = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outs", 64'({stall_D, md_busy, md_done, md_result, md_rd, md_we}), 64'd0);
    check_val("reset_state", 64'(md_state_dbg), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("mul_7x6",    1'b0, 1'b0, 1'b0, 32'd7,          32'd6,          5'd5);
    run_op("mulh_s",     1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,  32'd1,          5'd1);
    run_op("mulhu",      1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,  32'd2,          5'd2);
    run_op("div_100_7",  1'b1, 1'b0, 1'b0, 32'd100,        32'd7,          5'd3);
    run_op("rem_100_7",  1'b1, 1'b0, 1'b1, 32'd100,        32'd7,          5'd4);
    run_op("div_s_m7_2", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          5'd6);
    run_op("rem_s_m7_2", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd7);
    run_op("div_5_0",    1'b1, 1'b0, 1'b0, 32'd5,          32'd0,          5'd8);
    run_op("rem_5_0",    1'b1, 1'b0, 1'b1, 32'd5,          32'd0,          5'd9);
    run_op("div_s_m5_0", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          5'd10);
    run_op("rem_s_m5_0", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,          5'd11);
    run_op("div_ovf",    1'b1, 1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12);
    run_op("rem_ovf",    1'b1, 1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13);
    run_op("div_big",    1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd14);
    run_op("mul_rd0",    1'b0, 1'b0, 1'b0, 32'd9,          32'd9,          5'd0);
    run_op("mul_b0",     1'b0, 1'b1, 1'b0, 32'd123,        32'd0,          5'd15);

    // Random mix
    for (int i = 0; i < 12; i++) begin
      ra   = $urandom;
      rb   = (i % 4 == 3) ? XLEN'($urandom_range(0, 20)) : $urandom;
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ralt = 1'($urandom_range(0, 1));
      run_op("rand", rdiv, rsgn, ralt, ra, rb, 5'($urandom_range(1, 31)));
    end

    // Back-to-back: second op presented in the DONE cycle of the first
    issue(1'b1, 1'b0, 1'b0, 32'd1000, 32'd10, 5'd20, 1'b1);
    wait_done("b2b_first", exp_lat(1'b1, 1'b0, 32'd10));
    issue(1'b0, 1'b0, 1'b0, 32'd3, 32'd2, 5'd21, 1'b1);
    wait_done("b2b_second", exp_lat(1'b0, 1'b0, 32'd2));
    @(negedge clk);

    // Flush at cycle 10 of a divide: IDLE at cycle 11, no md_done
    issue(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 5'd22, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_val("flush_state", 64'(md_state_dbg), 64'd0);
    check_val("flush_busy", 64'({stall_D, md_busy}), 64'd0);
    repeat (40) @(negedge clk);

    // Flush on an accept cycle blocks the accept
    EX_md_valid = 1'b1; EX_md_div = 1'b0; EX_ra_val = 32'd4; EX_rb_val = 32'd4;
    EX_rd = 5'd23; flush = 1'b1;
    #1;
    check_val("flush_acc_stall", 64'(stall_D), 64'd0);
    @(posedge clk);
    #1;
    EX_md_valid = 1'b0; flush = 1'b0;
    check_val("flush_acc_busy", 64'(md_busy), 64'd0);
    @(negedge clk);

    // Good op after the flushes
    run_op("post_flush", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 5'd24);

    // Async reset mid-op
    issue(1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 5'd25, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_outs", 64'({stall_D, md_busy, md_done, md_result, md_rd, md_we}), 64'd0);
    check_val("rst_mid_state", 64'(md_state_dbg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
